tnet_axi_reg_mst: RTL and testbench

// - AXI4-Lite initiator: turns single register commands (write/read) into AXI-Lite transactions toward the TNET register slave.
// - Sits between a local controller (sequencer/test engine) and the TNET register block's 6-bit AXI-Lite slave port.
// - One outstanding transaction; result (read data + BRESP/RRESP) returned on a response handshake.

---
 rtl/tnet_axi_reg_mst.sv | 152 +++++++++++++++
 tb/tb_tnet_axi_reg_mst.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/tnet_axi_reg_mst.sv
// tnet_axi_reg_mst: AXI4-Lite initiator turning single register write/read commands into AXI-Lite transactions
// Ports: ps_aclk/ps_rst (sync, active-high) clock and reset;
//        cmd_* command handshake (wr, byte addr, wdata), accepted when cmd_valid & cmd_ready;
//        rsp_* result handshake (rdata, BRESP/RRESP, timeout flag), held until rsp_ready;
//        m_axi_* AXI4-Lite master channels AW/W/B/AR/R, one outstanding transaction.
// Build option: define TNET_AXI_MST_TIMEOUT_EN to abort any wait phase after TIMEOUT_CYC cycles.
module tnet_axi_reg_mst #(
   parameter int ADDR_W      = 6,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                ps_aclk,
   input  logic                ps_rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_wr,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [1:0]          rsp_resp,
   output logic                rsp_timeout,
   output logic [ADDR_W-1:0]   m_axi_awaddr,
   output logic [2:0]          m_axi_awprot,
   output logic                m_axi_awvalid,
   input  logic                m_axi_awready,
   output logic [DATA_W-1:0]   m_axi_wdata,
   output logic [DATA_W/8-1:0] m_axi_wstrb,
   output logic                m_axi_wvalid,
   input  logic                m_axi_wready,
   input  logic [1:0]          m_axi_bresp,
   input  logic                m_axi_bvalid,
   output logic                m_axi_bready,
   output logic [ADDR_W-1:0]   m_axi_araddr,
   output logic [2:0]          m_axi_arprot,
   output logic                m_axi_arvalid,
   input  logic                m_axi_arready,
   input  logic [DATA_W-1:0]   m_axi_rdata,
   input  logic [1:0]          m_axi_rresp,
   input  logic                m_axi_rvalid,
   output logic                m_axi_rready
);
   typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;
   state_t state;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata_q;
   logic hs, tmo;
   assign m_axi_awaddr = addr;
   assign m_axi_araddr = addr;
   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;
   assign m_axi_wdata  = wdata_q;
   assign m_axi_wstrb  = '1;
   // hs: the current wait phase completes this cycle (write address phase needs both AW and W done)
   always_comb
      hs = (state == WR_AW_W) ? ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) :
           (state == WR_B)    ? m_axi_bvalid :
           (state == RD_AR)   ? m_axi_arready :
           (state == RD_R)    ? m_axi_rvalid : 1'b0;
`ifdef TNET_AXI_MST_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] cnt;
   logic tmo_q;
   // counter restarts whenever a phase completes, so each new phase starts from zero
   always_comb tmo = (state != IDLE) && (state != RSP) && !hs && (cnt == CW'(TIMEOUT_CYC - 1));
   always_ff @(posedge ps_aclk) begin
      if (ps_rst || hs || state == IDLE || state == RSP) cnt <= '0;
      else cnt <= cnt + 1'b1;
      if (ps_rst) tmo_q <= 1'b0;
      else if (tmo) tmo_q <= 1'b1;
      else if (state == RSP && rsp_ready) tmo_q <= 1'b0;
   end
   assign rsp_timeout = tmo_q;
`else
   assign tmo = 1'b0;
   assign rsp_timeout = 1'b0;
`endif
   always_ff @(posedge ps_aclk) begin
      if (ps_rst) begin
         state         <= IDLE;
         cmd_ready     <= 1'b1;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_resp      <= 2'b00;
         addr          <= '0;
         wdata_q       <= '0;
      end else begin
         case (state)
            IDLE: if (cmd_valid) begin
               cmd_ready     <= 1'b0;
               addr          <= cmd_addr & ~ADDR_W'(3);
               wdata_q       <= cmd_wdata;
               m_axi_awvalid <= cmd_wr;
               m_axi_wvalid  <= cmd_wr;
               m_axi_arvalid <= !cmd_wr;
               state         <= cmd_wr ? WR_AW_W : RD_AR;
            end
            WR_AW_W: begin
               if (m_axi_awready) m_axi_awvalid <= 1'b0;
               if (m_axi_wready) m_axi_wvalid <= 1'b0;
               if (hs) begin
                  m_axi_bready <= 1'b1;
                  state        <= WR_B;
               end
            end
            WR_B: if (hs) begin
               m_axi_bready <= 1'b0;
               rsp_resp     <= m_axi_bresp;
               rsp_rdata    <= '0;
               rsp_valid    <= 1'b1;
               state        <= RSP;
            end
            RD_AR: if (hs) begin
               m_axi_arvalid <= 1'b0;
               m_axi_rready  <= 1'b1;
               state         <= RD_R;
            end
            RD_R: if (hs) begin
               m_axi_rready <= 1'b0;
               rsp_rdata    <= m_axi_rdata;
               rsp_resp     <= m_axi_rresp;
               rsp_valid    <= 1'b1;
               state        <= RSP;
            end
            RSP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               cmd_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // abort overrides whatever the phase logic scheduled above
         if (tmo) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b10;
            rsp_valid     <= 1'b1;
            state         <= RSP;
         end
      end
   end
endmodule

// File: tb/tb_tnet_axi_reg_mst.sv
// tb_tnet_axi_reg_mst: directed stimulus with a response scoreboard for tnet_axi_reg_mst
module tb_tnet_axi_reg_mst;
   typedef struct packed {
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic        tmo;
   } exp_t;
   logic        ps_aclk = 1'b0;
   logic        ps_rst;
   logic        cmd_valid, cmd_ready, cmd_wr;
   logic [5:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [5:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   exp_t        q[$];
   int          checks = 0;
   int          failures = 0;
   int          n;
   tnet_axi_reg_mst #(.ADDR_W(6), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
      .ps_aclk(ps_aclk), .ps_rst(ps_rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
   );
   always #5 ps_aclk = ~ps_aclk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge ps_aclk);
      #1;
   endtask
   task automatic issue(input logic wr, input logic [5:0] a, input logic [31:0] d);
      cmd_valid = 1'b1;
      cmd_wr    = wr;
      cmd_addr  = a;
      cmd_wdata = d;
      tick();
      cmd_valid = 1'b0;
   endtask
   always @(negedge ps_aclk) begin
      if (!ps_rst && rsp_valid && rsp_ready) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp: got rdata=%h resp=%0d with no response expected", rsp_rdata, rsp_resp);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_resp", 32'(rsp_resp), 32'(e.resp));
            check("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end
   initial begin
      ps_rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
      tick(); tick();
      ps_rst = 1'b0;
      check("rst_cmd_ready", 32'(cmd_ready), 1);
      check("rst_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata[27:0]}, 0);
      check("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
      // write 0x0C, AW/W ready in the first valid cycle, OKAY response
      q.push_back('{32'h0, 2'b00, 1'b0});
      issue(1'b1, 6'h0F, 32'hDEADBEEF);
      check("w1_valids", {awvalid, wvalid, cmd_ready}, 3'b110);
      check("w1_awaddr", 32'(awaddr), 32'h0C);
      check("w1_wdata", wdata, 32'hDEADBEEF);
      check("w1_wstrb_prot", {wstrb, awprot}, {4'hF, 3'b000});
      awready = 1'b1; wready = 1'b1;
      tick();
      awready = 1'b0; wready = 1'b0;
      check("w1_b_phase", {awvalid, wvalid, bready}, 3'b001);
      bvalid = 1'b1; bresp = 2'b00;
      tick();
      bvalid = 1'b0;
      check("w1_rsp_valid_t3", {rsp_valid, bready}, 2'b10);
      tick();
      check("w1_idle", {cmd_ready, rsp_valid}, 2'b10);
      // write 0x08, W accepted three cycles before AW
      q.push_back('{32'h0, 2'b00, 1'b0});
      issue(1'b1, 6'h08, 32'h00000005);
      wready = 1'b1;
      tick();
      wready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("w2_aw_held", {awvalid, wvalid, bready}, 3'b100);
         if (i < 2) tick();
      end
      awready = 1'b1;
      tick();
      awready = 1'b0;
      check("w2_b_phase", {awvalid, wvalid, bready}, 3'b001);
      bvalid = 1'b1;
      tick();
      bvalid = 1'b0;
      check("w2_bready_drop", {bready, rsp_valid}, 2'b01);
      tick(); tick(); tick();
      check("w2_single_rsp", {rsp_valid, cmd_ready}, 2'b01);
      // read 0x04 with a five-cycle arready stall
      q.push_back('{32'h12345678, 2'b00, 1'b0});
      issue(1'b0, 6'h04, 32'hFFFFFFFF);
      for (int i = 0; i < 5; i++) begin
         check("r1_ar_held", {arvalid, rready, awvalid}, 3'b100);
         check("r1_araddr", 32'(araddr), 32'h04);
         tick();
      end
      arready = 1'b1;
      tick();
      arready = 1'b0;
      check("r1_r_phase", {arvalid, rready}, 2'b01);
      rvalid = 1'b1; rdata = 32'h12345678; rresp = 2'b00;
      tick();
      rvalid = 1'b0; rdata = '0;
      check("r1_rsp_valid", {rsp_valid, rready}, 2'b10);
      tick();
      // read 0x3C with SLVERR, response held for four cycles, a command offered during RSP
      rsp_ready = 1'b0;
      q.push_back('{32'hA5A50F0F, 2'b10, 1'b0});
      issue(1'b0, 6'h3C, 32'h0);
      check("r2_araddr", 32'(araddr), 32'h3C);
      arready = 1'b1;
      tick();
      arready = 1'b0;
      rvalid = 1'b1; rdata = 32'hA5A50F0F; rresp = 2'b10;
      tick();
      rvalid = 1'b0; rdata = '0; rresp = 2'b00;
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 6'h10; cmd_wdata = 32'h1;
      for (int i = 0; i < 4; i++) begin
         check("r2_hold_valid", {rsp_valid, cmd_ready, awvalid}, 3'b100);
         check("r2_hold_data", rsp_rdata, 32'hA5A50F0F);
         check("r2_hold_resp", 32'(rsp_resp), 32'h2);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      check("r2_cmd_not_taken", {cmd_ready, awvalid, wvalid, rsp_valid}, 4'b1000);
      cmd_valid = 1'b0;
      tick();
      // reset while awvalid is pending drops everything with no response
      issue(1'b1, 6'h20, 32'h77);
      tick();
      check("rst_mid_pending", 32'(awvalid), 1);
      ps_rst = 1'b1;
      tick();
      ps_rst = 1'b0;
      check("rst_mid_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
      check("rst_mid_state", {cmd_ready, rsp_valid}, 2'b10);
      tick(); tick(); tick();
      check("rst_mid_no_rsp", 32'(rsp_valid), 0);
`ifdef TNET_AXI_MST_TIMEOUT_EN
      // B never arrives: abort after 16 cycles in WR_B
      q.push_back('{32'h0, 2'b10, 1'b1});
      issue(1'b1, 6'h14, 32'h55);
      awready = 1'b1; wready = 1'b1;
      tick();
      awready = 1'b0; wready = 1'b0;
      check("to_b_phase", 32'(bready), 1);
      n = 0;
      while (!rsp_valid && n < 100) begin
         tick();
         n++;
      end
      check("to_cycles", n, 16);
      check("to_dropped", {bready, awvalid, wvalid}, 0);
      tick(); tick();
      check("to_idle", {cmd_ready, rsp_valid, rsp_timeout}, 3'b100);
`endif
      tick(); tick();
      check("queue_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
